// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among NUM_REQ clients.
// Two-stage in-flight tracking returns data to the owner with a one-cycle ack.
module rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [ADDR_WIDTH-1:0]         o_rom_addr,
  input  logic [DATA_WIDTH-1:0]         i_rom_data
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [OWN_W-1:0] own_t;

  // Explicit wrap keeps non-power-of-two client counts correct.
  function automatic own_t f_next(own_t v);
    if (int'(v) >= NUM_REQ - 1) return '0;
    else                         return v + own_t'(1);
  endfunction

  logic [NUM_REQ-1:0]    r_pending;
  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  own_t                  r_ptr;
  logic                  r_s1_vld;
  own_t                  r_s1_own;
  logic                  r_s2_vld;
  own_t                  r_s2_own;

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_hit;
  own_t                  w_win;
  logic [NUM_REQ-1:0]    w_set;
  logic [NUM_REQ-1:0]    w_clr;
  logic [ADDR_WIDTH-1:0] w_win_addr;

  // A client acked this cycle is masked so a held request is not re-granted early.
  always_comb begin
    own_t v_idx;
    w_elig = i_req & ~r_pending & ~r_ack;
    w_hit  = 1'b0;
    w_win  = r_ptr;
    v_idx  = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = f_next(v_idx);
      if (!w_hit && w_elig[v_idx]) begin
        w_hit = 1'b1;
        w_win = v_idx;
      end
    end
  end

  always_comb begin
    w_win_addr = i_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    w_set      = '0;
    w_clr      = '0;
    if (w_hit)    w_set[w_win]    = 1'b1;
    if (r_s2_vld) w_clr[r_s2_own] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending  <= '0;
      r_ack      <= '0;
      r_data     <= '0;
      r_rom_addr <= '0;
      r_ptr      <= own_t'(NUM_REQ - 1);
      r_s1_vld   <= 1'b0;
      r_s1_own   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_own   <= '0;
    end else begin
      r_s1_vld <= w_hit;
      if (w_hit) begin
        r_rom_addr <= w_win_addr;
        r_s1_own   <= w_win;
        r_ptr      <= w_win;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_own  <= r_s1_own;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_ack     <= w_clr;
      if (r_s2_vld) r_data <= i_rom_data;
    end
  end

  assign o_ack      = r_ack;
  assign o_data     = r_data;
  assign o_rom_addr = r_rom_addr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered-read ROM model.
// ROM content: 0x15 -> 0xBEEF, every other address a -> 0x100 + a.
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] addr;
  logic [3:0]  ack;
  logic [15:0] data;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;

  int n_chk  = 0;
  int n_pass = 0;

  rom_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_addr     (addr),
    .o_ack      (ack),
    .o_data     (data),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(logic [7:0] a);
    if (a == 8'h15) return 16'hBEEF;
    return 16'h0100 + {8'h00, a};
  endfunction

  always_ff @(posedge clk) rom_data <= rom_val(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_addr(input int k, input logic [7:0] a);
    addr[k*8 +: 8] = a;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cnt [4];
    int since [4];
    logic seen [4];
    int max_wait, total, multi, cmax, cmin, k;
    logic [3:0] eack;

    rst_n = 1'b1;
    req   = '0;
    addr  = '0;
    #1 rst_n = 1'b0;
    #1;

    // reset / idle
    check("rst_ack", ack, 0);
    check("rst_data", data, 0);
    check("rst_addr", rom_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("idle_ack", ack, 0);
    end
    check("idle_data", data, 0);

    // single client
    set_addr(2, 8'h15);
    req = 4'b0100;
    @(negedge clk);
    check("single_addr", rom_addr, 8'h15);
    check("single_ack_e0", ack, 0);
    @(negedge clk);
    check("single_ack_e1", ack, 0);
    @(negedge clk);
    check("single_ack_e2", ack, 4'b0100);
    check("single_data", data, 16'hBEEF);
    req = '0;
    @(negedge clk);
    check("single_ack_e3", ack, 0);
    check("single_hold", data, 16'hBEEF);

    // contention, client 0 first after reset
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      if (s <= 3) check("cont_addr", rom_addr, 8'h10 + 8'(s));
      eack = (s >= 2 && s <= 5) ? (4'b0001 << (s - 2)) : 4'b0000;
      check("cont_ack", ack, eack);
      if (s >= 2 && s <= 5) check("cont_data", data, 16'h0110 + 16'(s - 2));
      req = req & ~ack;
    end

    // fairness with continuous requests
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; since[i] = 0; seen[i] = 1'b0; end
    max_wait = 0; total = 0; multi = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if ($countones(ack) > 1) multi++;
      if ($countones(ack) == 1) begin
        total++;
        k = 0;
        for (int i = 0; i < 4; i++) if (ack[i]) k = i;
        cnt[k]++;
        if (seen[k] && since[k] > max_wait) max_wait = since[k];
        seen[k]  = 1'b1;
        since[k] = 0;
        for (int i = 0; i < 4; i++) if (i != k) since[i]++;
      end
    end
    req = '0;
    cmax = cnt[0]; cmin = cnt[0];
    for (int i = 1; i < 4; i++) begin
      if (cnt[i] > cmax) cmax = cnt[i];
      if (cnt[i] < cmin) cmin = cnt[i];
    end
    check("fair_total", total, 38);
    check("fair_multi", multi, 0);
    check("fair_spread", cmax - cmin, 1);
    check("fair_wait", max_wait, 3);
    repeat (4) @(negedge clk);

    // back-to-back same client, request held through ack
    do_reset();
    set_addr(1, 8'h22);
    req = 4'b0010;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      eack = (s == 2 || s == 6 || s == 10) ? 4'b0010 : 4'b0000;
      check("b2b_ack", ack, eack);
      if (eack != 0) check("b2b_data", data, 16'h0122);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // async reset with a read in flight
    do_reset();
    set_addr(3, 8'h31);
    req = 4'b1000;
    repeat (3) @(negedge clk);
    check("ar_ack_pre", ack, 4'b1000);
    check("ar_data_pre", data, 16'h0131);
    req = '0;
    @(negedge clk);
    set_addr(3, 8'h30);
    req = 4'b1000;
    @(negedge clk);
    check("ar_addr", rom_addr, 8'h30);
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("ar_ack_now", ack, 0);
    check("ar_data_now", data, 0);
    check("ar_addr_now", rom_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("ar_no_stale", ack, 0);
    end
    check("ar_data_post", data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one `rom_sync` instance (1-cycle registered read) between up to `NUM_REQ` ROM clients, such as the pattern sequencers and pitch lookups of several channels. Each client gets its own request/acknowledge handshake. The arbiter drives the single ROM address port, tracks in-flight reads through a 2-stage pipeline, and returns data to the owning client with a one-cycle acknowledge. One read can be issued per cycle, so several channels share one block RAM with no throughput loss.

## Interface
- `NUM_REQ`, 4: number of clients, legal range 2..8.
- `ADDR_WIDTH`, 8: ROM address width.
- `DATA_WIDTH`, 16: ROM data width.
- `i_clk`  in  1  sole clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_req`  in  NUM_REQ  level request per client; held until that client's `o_ack` pulse.
- `i_addr`  in  NUM_REQ*ADDR_WIDTH  flattened per-client addresses; client k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]. Must be stable while `i_req[k]` is high.
- `o_ack`  out  NUM_REQ  one-hot, one-cycle pulse; `o_data` is valid for that client.
- `o_data`  out  DATA_WIDTH  read data, shared by all clients; holds its value between acks.
- `o_rom_addr`  out  ADDR_WIDTH  address to the shared `rom_sync`.
- `i_rom_data`  in  DATA_WIDTH  `rom_sync` output; valid one cycle after `o_rom_addr` is sampled.

## Operation
- Reset values: `o_ack`=0, `o_data`=0, `o_rom_addr`=0, all pipeline valids=0, pending mask=0, round-robin pointer=NUM_REQ-1 (client 0 has highest priority first).
- Eligible set = `i_req` & ~pending & ~`o_ack`. A client is pending from the edge where it is granted until the edge where its `o_ack` is asserted.
  - Masking with `o_ack` means a request still high during the ack cycle is not re-granted. The client must drop `i_req` by the next edge, or that request is treated as a new one.
- Arbitration happens on every edge with no idle state.
  - Search the eligible set starting at pointer+1 and wrap modulo NUM_REQ. The first hit k wins.
  - On a win: register `o_rom_addr` <= addr[k]; set stage-1 valid and owner=k; set pending[k]; set pointer <= k.
  - If the eligible set is empty: clear stage-1 valid; `o_rom_addr` and the pointer hold their values.
- Stage 2: stage-2 valid/owner <= stage-1 valid/owner. This aligns with the ROM's registered read.
- Completion: when stage-2 is valid at an edge, `o_data` <= `i_rom_data`, `o_ack[owner]` <= 1 for exactly one cycle, and pending[owner] is cleared. Otherwise `o_ack` <= 0 and `o_data` holds.
- Owner ids are `$clog2(NUM_REQ)` bits wide. Pointer wrap from NUM_REQ-1 to 0 is explicit, so non-power-of-two NUM_REQ is correct.
- Up to 2 reads are in flight at once, each for a different client, plus 1 ack cycle. Results complete strictly in issue order.
- Reset mid-operation: all in-flight reads are discarded and no ack is produced for them. Clients must re-request after reset.

## Timing
- Edge E0 samples `i_req[k]` high and grants k; `o_rom_addr` is valid after E0.
- E1: ROM captures the data.
- E2: `o_data` is updated and `o_ack[k]` is high from E2 to E3.
- Request-to-ack latency: 3 cycles.
- Sustained throughput: 1 grant per cycle across clients. Per client, at most 1 grant per 4 cycles (earliest re-grant is E4).
- Simultaneous requests: all N clients asserting in the same cycle are served on N consecutive edges in round-robin order.
- Fairness: with all clients requesting continuously, no client waits more than NUM_REQ-1 grants of other clients.

## Test plan
- Reset/idle: hold `i_rst_n`=0, then release with `i_req`=0 -> all outputs stay 0 and `o_ack` never pulses.
- Single client: client 2 requests addr 0x15, ROM[0x15]=0xBEEF -> `o_rom_addr`=0x15 after E0; `o_ack`=4'b0100 and `o_data`=0xBEEF after E2, for exactly 1 cycle.
- Contention: clients 0–3 request addrs 0x10–0x13 in the same cycle (ROM[a]=a+0x100) -> acks for clients 0,1,2,3 arrive on consecutive cycles with data 0x110–0x113.
- Fairness: all clients hold `i_req` continuously and re-request after each ack -> over 40 cycles the grant counts differ by ≤1 and no client waits more than 3 grants.
- Back-to-back same client: client 1 keeps `i_req` high through its ack cycle -> exactly one ack per grant, with the next grant no earlier than 4 cycles after the previous one.
- Async reset mid-flight: assert `i_rst_n`=0 one cycle after granting client 3, between clock edges -> `o_ack` and `o_data` clear immediately, and no stale ack appears after release.
